// File: rtl/mdio_pkg.sv
// mdio_pkg: shared definitions for the Clause-22 MDIO management controller.
// Holds the OP and ST codes, the controller state encoding, the bit positions
// of every field in the 32-bit frame word, and small opcode helpers.
package mdio_pkg;

    localparam logic [1:0] OP_WRITE   = 2'b01;
    localparam logic [1:0] OP_READ    = 2'b10;
    localparam logic [1:0] START_CODE = 2'b01;

    localparam int FRAME_BITS = 32;

    // Frame field bit positions inside the 32-bit word
    localparam int ST_MSB    = 31;
    localparam int ST_LSB    = 30;
    localparam int OP_MSB    = 29;
    localparam int OP_LSB    = 28;
    localparam int PHYAD_MSB = 27;
    localparam int PHYAD_LSB = 23;
    localparam int REGAD_MSB = 22;
    localparam int REGAD_LSB = 18;
    localparam int TA_MSB    = 17;
    localparam int TA_LSB    = 16;
    localparam int DATA_MSB  = 15;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        FRAME    = 2'd2,
        DONE     = 2'd3
    } mdio_state_e;

    // Only write and read opcodes start a transaction
    function automatic logic op_is_valid(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

    function automatic logic op_is_read(input logic [1:0] op);
        return (op == OP_READ);
    endfunction

endpackage

// File: rtl/mdc_gen.sv
// mdc_gen: divides clk into the MDC management clock.
// Each MDC period is DIV clk cycles: low for the first DIV/2, high for the last DIV/2.
// Ports:
//   clk, rst   block clock, asynchronous active-high reset
//   en         run the divider; when low the count restarts and MDC is held low
//   mdc        registered management clock
//   mdc_rise   one-clk strobe in the cycle whose closing edge raises MDC
//   mdc_fall   one-clk strobe in the last cycle of a period (MDC falls at its closing edge)
module mdc_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF    = CW'(DIV / 2);
    localparam logic [CW-1:0] RISE_AT = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic          mdc_r;

    // Next divider count: wraps at DIV-1, restarts whenever disabled
    always_comb begin
        cnt_next_s = '0;
        if (en) begin
            if (cnt_r == LAST) begin
                cnt_next_s = '0;
            end else begin
                cnt_next_s = cnt_r + CW'(1);
            end
        end else begin
            cnt_next_s = '0;
        end
    end

    // Divider count and MDC flop; MDC is decoded from the count it will hold next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            mdc_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            mdc_r <= en && (cnt_next_s >= HALF);
        end
    end

    assign mdc      = mdc_r;
    assign mdc_rise = en && (cnt_r == RISE_AT);
    assign mdc_fall = en && (cnt_r == LAST);

endmodule

// File: rtl/mdio_controller.sv
// mdio_controller: Clause-22 MDIO master.
// Accepts a 32-bit frame on MDIO_START, optionally sends a preamble of PRE_LEN ones,
// shifts the frame out MSB first and, for reads, captures 16 data bits from MDIO_IN.
// Ports:
//   CLK, RESET          block clock, asynchronous active-high reset
//   MDIO_START, T_DATA  one-clk request strobe and the frame word
//   MDIO_IN             serial data from the peripheral
//   MDC                 management clock
//   MDIO_OE, MDIO_OUT   serial output enable and data
//   RD_DATA, DATA_RDY   last read word and its one-clk valid pulse
//   BUSY                transaction in progress
module mdio_controller
    import mdio_pkg::*;
#(
    parameter int DIV     = 4,
    parameter int PRE_LEN = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OE,
    output logic        MDIO_OUT,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        BUSY
);

    // Bit counter covers whichever phase is longer, so it never wraps
    localparam int CNT_MAX = (PRE_LEN > FRAME_BITS) ? PRE_LEN : FRAME_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = (PRE_LEN > 0) ? CNT_W'(PRE_LEN - 1) : '0;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    mdio_state_e       state_r, state_next_s;
    logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_next_s;
    logic [31:0]       frame_r, frame_next_s;
    logic [15:0]       shift_r, shift_next_s;
    logic [15:0]       rd_data_r, rd_data_next_s;
    logic              oe_r, oe_next_s;
    logic              out_r, out_next_s;
    logic              busy_r, busy_next_s;
    logic              rdy_r, rdy_next_s;
    logic              accept_s, running_s;
    logic              mdc_s, mdc_rise_s, mdc_fall_s;
    logic [4:0]        bit_idx_s, bit_idx_next_s;

    assign running_s = (state_r == PREAMBLE) || (state_r == FRAME);
    assign accept_s  = MDIO_START && (state_r == IDLE) && op_is_valid(T_DATA[OP_MSB:OP_LSB]);
    assign frame_next_s = accept_s ? T_DATA : frame_r;

    // Frame bit index (31 down to 0) of the current and of the next cycle
    assign bit_idx_s      = 5'd31 - bit_cnt_r[4:0];
    assign bit_idx_next_s = 5'd31 - bit_cnt_next_s[4:0];

    mdc_gen #(.DIV(DIV)) u_mdc_gen (
        .clk      (CLK),
        .rst      (RESET),
        .en       (running_s),
        .mdc      (mdc_s),
        .mdc_rise (mdc_rise_s),
        .mdc_fall (mdc_fall_s)
    );

    // State and bit counter registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r   <= IDLE;
            bit_cnt_r <= '0;
        end else begin
            state_r   <= state_next_s;
            bit_cnt_r <= bit_cnt_next_s;
        end
    end

    // Next state and bit count; bits advance on the last clk of each MDC period
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        case (state_r)
            IDLE: begin
                bit_cnt_next_s = '0;
                if (accept_s) begin
                    state_next_s = (PRE_LEN > 0) ? PREAMBLE : FRAME;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PREAMBLE: begin
                if (mdc_fall_s && (bit_cnt_r == PRE_LAST)) begin
                    state_next_s   = FRAME;
                    bit_cnt_next_s = '0;
                end else if (mdc_fall_s) begin
                    bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
                end else begin
                    bit_cnt_next_s = bit_cnt_r;
                end
            end
            FRAME: begin
                if (mdc_fall_s && (bit_cnt_r == FRAME_LAST)) begin
                    state_next_s   = DONE;
                    bit_cnt_next_s = '0;
                end else if (mdc_fall_s) begin
                    bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
                end else begin
                    bit_cnt_next_s = bit_cnt_r;
                end
            end
            DONE: begin
                state_next_s   = IDLE;
                bit_cnt_next_s = '0;
            end
            default: begin
                state_next_s   = IDLE;
                bit_cnt_next_s = '0;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from next state and bit position
    always_comb begin
        oe_next_s      = 1'b0;
        out_next_s     = 1'b0;
        busy_next_s    = 1'b0;
        rdy_next_s     = 1'b0;
        rd_data_next_s = rd_data_r;
        case (state_next_s)
            PREAMBLE: begin
                busy_next_s = 1'b1;
                oe_next_s   = 1'b1;
                out_next_s  = 1'b1;
            end
            FRAME: begin
                busy_next_s = 1'b1;
                // Reads release the line from the turnaround onwards
                if (!op_is_read(frame_next_s[OP_MSB:OP_LSB]) || (bit_idx_next_s >= 5'(REGAD_LSB))) begin
                    oe_next_s  = 1'b1;
                    out_next_s = frame_next_s[bit_idx_next_s];
                end else begin
                    oe_next_s  = 1'b0;
                    out_next_s = 1'b0;
                end
            end
            DONE: begin
                busy_next_s = 1'b1;
                if (op_is_read(frame_r[OP_MSB:OP_LSB])) begin
                    rdy_next_s     = 1'b1;
                    rd_data_next_s = shift_r;
                end else begin
                    rdy_next_s     = 1'b0;
                    rd_data_next_s = rd_data_r;
                end
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Read data capture on the clk edge that raises MDC, data bits only
    always_comb begin
        shift_next_s = shift_r;
        if ((state_r == FRAME) && op_is_read(frame_r[OP_MSB:OP_LSB]) && mdc_rise_s
            && (bit_idx_s <= 5'(DATA_MSB))) begin
            shift_next_s = {shift_r[14:0], MDIO_IN};
        end else begin
            shift_next_s = shift_r;
        end
    end

    // Frame latch, read shift register and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frame_r   <= 32'h0000_0000;
            shift_r   <= 16'h0000;
            rd_data_r <= 16'h0000;
            oe_r      <= 1'b0;
            out_r     <= 1'b0;
            busy_r    <= 1'b0;
            rdy_r     <= 1'b0;
        end else begin
            frame_r   <= frame_next_s;
            shift_r   <= shift_next_s;
            rd_data_r <= rd_data_next_s;
            oe_r      <= oe_next_s;
            out_r     <= out_next_s;
            busy_r    <= busy_next_s;
            rdy_r     <= rdy_next_s;
        end
    end

    assign MDC      = mdc_s;
    assign MDIO_OE  = oe_r;
    assign MDIO_OUT = out_r;
    assign RD_DATA  = rd_data_r;
    assign DATA_RDY = rdy_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_mdio_controller.sv
// tb_mdio_controller: scoreboard bench for mdio_controller at DIV=4, PRE_LEN=32.
// Stimulus pushes the expected serial stream and read word per accepted frame;
// a negedge monitor also plays the PHY, records MDIO at every MDC rise and
// compares each completed transaction against the queued expectation.
module tb_mdio_controller;

    localparam int DIV_T    = 4;
    localparam int PRE_T    = 32;
    localparam int NBITS    = PRE_T + 32;
    localparam int BUSY_LEN = NBITS * DIV_T + 1;

    logic        CLK;
    logic        RESET;
    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] td;
        logic        is_read;
        logic [15:0] rv;
        logic [63:0] exp_out;
        logic [63:0] exp_oe;
    } sb_t;

    sb_t exp_q[$];

    mdio_controller #(.DIV(DIV_T), .PRE_LEN(PRE_T)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MDIO_START (MDIO_START),
        .T_DATA     (T_DATA),
        .MDIO_IN    (MDIO_IN),
        .MDC        (MDC),
        .MDIO_OE    (MDIO_OE),
        .MDIO_OUT   (MDIO_OUT),
        .RD_DATA    (RD_DATA),
        .DATA_RDY   (DATA_RDY),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: what the line must carry, bit by bit, for a frame word
    function automatic sb_t make_exp(input logic [31:0] td, input logic [15:0] rv);
        sb_t e;
        int  idx;
        e.td      = td;
        e.rv      = rv;
        e.is_read = (td[29:28] == 2'b10);
        e.exp_out = 64'h0;
        e.exp_oe  = 64'h0;
        for (int p = 0; p < NBITS; p++) begin
            if (p < PRE_T) begin
                e.exp_out[63-p] = 1'b1;
                e.exp_oe[63-p]  = 1'b1;
            end else begin
                idx = 31 - (p - PRE_T);
                e.exp_oe[63-p]  = (!e.is_read || idx >= 18);
                e.exp_out[63-p] = e.exp_oe[63-p] ? td[idx] : 1'b0;
            end
        end
        return e;
    endfunction

    // Drive a one-cycle start from a negedge; queue the expectation if it should be taken
    task automatic issue(input logic [31:0] td, input logic [15:0] rv, input bit accept);
        T_DATA     = td;
        MDIO_START = 1'b1;
        if (accept) exp_q.push_back(make_exp(td, rv));
        @(negedge CLK);
        MDIO_START = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY === 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("busy_clears", {63'h0, BUSY}, 64'h0);
    endtask

    // Monitor, PHY model and scoreboard comparison
    initial begin : monitor
        bit          in_txn;
        bit          busy_prev;
        bit          mdc_prev;
        int          busy_cnt;
        int          rise_cnt;
        int          rdy_cnt;
        int          rdy_at;
        int          idx;
        logic [15:0] rdy_val;
        logic [15:0] last_rd;
        logic [63:0] obs_out;
        logic [63:0] obs_oe;
        sb_t         e;
        in_txn = 0; busy_prev = 0; mdc_prev = 0;
        busy_cnt = 0; rise_cnt = 0; rdy_cnt = 0; rdy_at = 0;
        rdy_val = 16'h0; last_rd = 16'h0; obs_out = 64'h0; obs_oe = 64'h0;
        forever begin
            @(negedge CLK);
            if (RESET === 1'b1) begin
                if (in_txn) begin
                    chk("abort_no_rdy", 64'(rdy_cnt), 64'h0);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    in_txn = 0;
                end
                last_rd   = 16'h0;
                busy_prev = 0;
                MDIO_IN   = 1'b0;
            end else begin
                if (BUSY && !busy_prev) begin
                    in_txn = 1; busy_cnt = 0; rise_cnt = 0; rdy_cnt = 0;
                    obs_out = 64'h0; obs_oe = 64'h0;
                end
                if (BUSY) begin
                    busy_cnt++;
                    if (MDC && !mdc_prev) begin
                        if (rise_cnt < NBITS) begin
                            obs_out[63-rise_cnt] = MDIO_OUT;
                            obs_oe[63-rise_cnt]  = MDIO_OE;
                        end
                        rise_cnt++;
                    end
                    if (DATA_RDY) begin
                        rdy_cnt++;
                        rdy_at  = busy_cnt;
                        rdy_val = RD_DATA;
                    end
                    if (busy_cnt == BUSY_LEN) chk("done_pins", {62'h0, MDC, MDIO_OE}, 64'h0);
                end else begin
                    chk("idle_pins", {60'h0, MDC, MDIO_OE, MDIO_OUT, DATA_RDY}, 64'h0);
                    if (busy_prev) begin
                        chk("sb_not_empty", 64'(exp_q.size() > 0), 64'h1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("busy_len", 64'(busy_cnt), 64'(BUSY_LEN));
                            chk("mdc_rises", 64'(rise_cnt), 64'(NBITS));
                            chk("serial_out", obs_out, e.exp_out);
                            chk("serial_oe", obs_oe, e.exp_oe);
                            chk("rdy_pulses", 64'(rdy_cnt), e.is_read ? 64'h1 : 64'h0);
                            if (e.is_read) begin
                                chk("rd_data", {48'h0, rdy_val}, {48'h0, e.rv});
                                chk("rdy_in_done", 64'(rdy_at), 64'(BUSY_LEN));
                                last_rd = e.rv;
                            end else begin
                                chk("rd_data_hold", {48'h0, RD_DATA}, {48'h0, last_rd});
                            end
                        end
                        in_txn = 0;
                    end
                end
                // PHY: present the current bit's read data while MDC is low
                if (in_txn && !MDC) begin
                    MDIO_IN = 1'b0;
                    if (rise_cnt >= PRE_T && rise_cnt < NBITS && exp_q.size() > 0) begin
                        idx = 31 - (rise_cnt - PRE_T);
                        if (exp_q[0].is_read && idx <= 15) MDIO_IN = exp_q[0].rv[idx];
                    end
                end
                busy_prev = BUSY;
            end
            mdc_prev = MDC;
        end
    end

    // Stimulus
    initial begin : stim
        int          n;
        logic [31:0] td;
        logic [15:0] rv;
        logic [1:0]  op;
        RESET = 1'b1; MDIO_START = 1'b0; T_DATA = 32'h0; MDIO_IN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_pins", {59'h0, MDC, MDIO_OE, MDIO_OUT, DATA_RDY, BUSY}, 64'h0);
        chk("reset_rd_data", {48'h0, RD_DATA}, 64'h0);
        RESET = 1'b0;
        @(negedge CLK);

        // Directed write, then a back-to-back read on the first idle cycle
        issue(32'h5096ABCD, 16'h0000, 1);
        wait_idle();
        issue(32'h60940000, 16'h1234, 1);
        wait_idle();

        // Invalid opcode must not start anything
        issue(32'h70940000, 16'h0000, 0);
        repeat (20) begin
            @(negedge CLK);
            chk("op11_busy", {63'h0, BUSY}, 64'h0);
        end

        // Start pulse with other data around frame bit 10 is ignored
        issue(32'h6A5C0000, 16'hBEEF, 1);
        repeat ((PRE_T + 21) * DIV_T) @(negedge CLK);
        T_DATA = 32'h5123FFFF; MDIO_START = 1'b1;
        @(negedge CLK);
        MDIO_START = 1'b0;
        wait_idle();

        // Start in the DONE cycle is ignored
        issue(32'h61BC0000, 16'hC3A5, 1);
        n = 0;
        while (DATA_RDY !== 1'b1 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("done_rdy_seen", {63'h0, DATA_RDY}, 64'h1);
        T_DATA = 32'h62220000; MDIO_START = 1'b1;
        @(negedge CLK);
        MDIO_START = 1'b0;
        repeat (3) begin
            chk("done_start_ignored", {63'h0, BUSY}, 64'h0);
            @(negedge CLK);
        end

        // Reset in the middle of a read's data bits
        issue(32'h6ABC0000, 16'hA55A, 1);
        repeat (220) @(posedge CLK);
        #1 RESET = 1'b1;
        #1;
        chk("async_reset_pins", {59'h0, MDC, MDIO_OE, MDIO_OUT, DATA_RDY, BUSY}, 64'h0);
        chk("async_reset_rd", {48'h0, RD_DATA}, 64'h0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        issue(32'h60F80000, 16'h0F0F, 1);
        wait_idle();

        // Randomised traffic, some back-to-back, some with gaps
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            td = $urandom;
            td[31:30] = 2'b01;
            td[29:28] = op;
            rv = 16'($urandom);
            issue(td, rv, 1);
            wait_idle();
        end

        repeat (4) @(negedge CLK);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdio_controller.md
MDIO_CONTROLLER -- requirements
Module: mdio_controller

Interface
REQ-001 Parameter DIV, default 4: CLK cycles per MDC period; even, >= 2.
REQ-002 Parameter PRE_LEN, default 32: preamble length in MDC cycles; 0 disables preamble.
REQ-003 CLK  input  1  single block clock; all logic on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 MDIO_START  input  1  one-CLK request strobe; T_DATA is valid in the same cycle.
REQ-006 T_DATA  input  32  Clause-22 frame: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] DATA.
REQ-007 MDIO_IN  input  1  serial data returned by the peripheral.
REQ-008 MDC  output  1  management clock to the peripheral.
REQ-009 MDIO_OE  output  1  high while the controller drives MDIO_OUT.
REQ-010 MDIO_OUT  output  1  serial data to the peripheral.
REQ-011 RD_DATA  output  16  last read data word.
REQ-012 DATA_RDY  output  1  one-CLK pulse; RD_DATA is valid.
REQ-013 BUSY  output  1  high while a transaction is in progress.

Function
REQ-014 The block SHALL use states IDLE, PREAMBLE, FRAME and DONE.
REQ-015 In IDLE, MDC=0, MDIO_OE=0, MDIO_OUT=0 and BUSY=0.
REQ-016 MDIO_START in IDLE with OP=01 (write) or OP=10 (read) SHALL latch T_DATA.
- Next state is PREAMBLE if PRE_LEN>0, otherwise FRAME.
- BUSY=1 from the next cycle.
REQ-017 MDIO_START with OP=00 or 11 SHALL be ignored; the block stays in IDLE with no output change.
REQ-018 MDIO_START while BUSY=1 SHALL be ignored; the latched frame is unaffected.
REQ-019 Each serial bit SHALL occupy exactly DIV CLK cycles.
- MDC=0 for the first DIV/2 cycles, MDC=1 for the last DIV/2 cycles.
- MDIO_OUT changes only at the bit's first cycle (MDC falling edge or bit start).
REQ-020 PREAMBLE SHALL drive MDIO_OUT=1, MDIO_OE=1 for PRE_LEN bits, then go to FRAME.
REQ-021 FRAME SHALL shift the latched word MSB first, bits 31 down to 0.
REQ-022 Write: MDIO_OE=1 for all 32 frame bits.
REQ-023 Read: MDIO_OE=1 for bits 31..18 and MDIO_OE=0 for bits 17..0; MDIO_OUT=0 while released.
REQ-024 Read: MDIO_IN SHALL be sampled on the CLK cycle where MDC rises, for bits 15..0.
- Samples shift MSB first into an internal shift register.
- RD_DATA is not altered during the shift.
REQ-025 After frame bit 0 completes, the block SHALL enter DONE for exactly one CLK, then return to IDLE.
- In DONE: MDC=0, MDIO_OE=0, BUSY=1.
- Read: RD_DATA is loaded and DATA_RDY=1 in the DONE cycle.
- Write: DATA_RDY stays 0 and RD_DATA holds its value.
REQ-026 Total BUSY time SHALL be (PRE_LEN+32)*DIV + 1 CLK cycles; 257 at the defaults.
REQ-027 MDIO_START in the DONE cycle SHALL be ignored; MDIO_START on the first IDLE cycle SHALL be accepted.
REQ-028 The bit counter and the divider counter SHALL be sized for the maximum value and SHALL NOT wrap inside a transaction.

Reset
REQ-029 RESET=1 SHALL immediately force, independent of CLK:
- state IDLE;
- MDC=0, MDIO_OE=0, MDIO_OUT=0;
- RD_DATA=16'h0000, DATA_RDY=0, BUSY=0;
- all counters and shift registers to 0.
REQ-030 Reset mid-transaction SHALL abandon the frame with no DATA_RDY pulse.
- The first MDIO_START accepted after RESET falls starts a fresh frame.

Structure
REQ-031 A shared package mdio_pkg SHALL hold:
- OP codes OP_WRITE=2'b01, OP_READ=2'b10;
- ST code 2'b01;
- the state encoding;
- frame field bit positions.
REQ-032 Sub-module mdc_gen SHALL generate MDC plus one-CLK mdc_rise and mdc_fall strobes from DIV.
- It has an enable input and is held low when disabled.

Verification
REQ-033 Write, PRE_LEN=32, DIV=4, T_DATA=32'h5096ABCD:
- 32 ones, then serial 0x5096ABCD MSB first;
- MDIO_OE=1 for all 64 bits;
- BUSY for 257 CLK; DATA_RDY never asserted.
REQ-034 Read, T_DATA=32'h60940000, bench drives 0x1234 on bits 15..0:
- MDIO_OE falls at bit 17;
- RD_DATA=16'h1234;
- DATA_RDY is a single pulse in the DONE cycle.
REQ-035 T_DATA=32'h70940000 (OP=11) with MDIO_START -> no MDC toggles; BUSY stays 0.
REQ-036 MDIO_START pulse with a different T_DATA at frame bit 10 -> ignored; the original frame completes unchanged.
REQ-037 RESET asserted mid-read at data bit 8, then a new read:
- outputs go to reset values immediately;
- no DATA_RDY pulse for the aborted read;
- the new read returns correct data.
REQ-038 Back-to-back reads: second MDIO_START on the first IDLE cycle after DONE -> accepted; both RD_DATA values correct.
